// File: rtl/ti3_present_sbox_pipe_if.sv
// Valid/ready stream bundle carrying three input shares, fresh randomness and
// three output shares for the masked PRESENT S-box layer.
interface ti3_present_sbox_pipe_if #(
    parameter int unsigned NUM_SBOX = 16
) ();
    localparam int unsigned RND_W = 16 * NUM_SBOX;

    logic                  in_valid;
    logic                  in_ready;
    logic [4*NUM_SBOX-1:0] in_sh0;
    logic [4*NUM_SBOX-1:0] in_sh1;
    logic [4*NUM_SBOX-1:0] in_sh2;
    logic [RND_W-1:0]      rnd;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*NUM_SBOX-1:0] out_sh0;
    logic [4*NUM_SBOX-1:0] out_sh1;
    logic [4*NUM_SBOX-1:0] out_sh2;

    modport master (
        output in_valid, in_sh0, in_sh1, in_sh2, rnd, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1, out_sh2
    );

    modport slave (
        input  in_valid, in_sh0, in_sh1, in_sh2, rnd, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1, out_sh2
    );
endinterface

// File: rtl/ti3_present_sbox_pipe.sv
// Three-share threshold implementation of the PRESENT S-box layer, S = Q2(Q1(x)),
// as a 3-stage pipeline that advances as a whole under a single enable.
module ti3_present_sbox_pipe #(
    parameter int unsigned NUM_SBOX     = 16,
    parameter bit          ZERO_ON_IDLE = 1'b1,
    parameter int unsigned RND_W        = 16 * NUM_SBOX
) (
    input logic                    clk,
    input logic                    rst_n,
    ti3_present_sbox_pipe_if.slave bus
);
    localparam int unsigned W = 4 * NUM_SBOX;

    // Nine expanded nibbles per S-box; entry 3*i+j depends only on shares i and j.
    typedef logic [8:0][3:0] exp_t;

    // One cross term of a quadratic layer for share pair (a = share i, b = share j).
    // Bit order within a nibble is {x, y, z, w} = {[3], [2], [1], [0]}.
    function automatic logic [3:0] q_term(input logic       layer2,
                                          input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       lin,
                                          input logic       cst);
        logic [3:0] g;
        logic [3:0] f;
        g[3] = lin & (a[2] ^ a[1] ^ a[0]);
        g[2] = (lin & (a[2] ^ a[1])) ^ cst;
        g[1] = (lin & (a[3] ^ a[1])) ^ cst ^ (a[2] & b[0]) ^ (a[1] & b[0]);
        g[0] = (lin & a[0]) ^ cst ^ (a[3] & b[2]) ^ (a[3] & b[1]) ^ (a[2] & b[1]);
        f[3] = (lin & (a[2] ^ a[1] ^ a[0])) ^ (a[3] & b[0]);
        f[2] = (lin & a[3]) ^ (a[1] & b[0]);
        f[1] = (lin & (a[2] ^ a[1])) ^ (a[3] & b[0]);
        f[0] = (lin & a[1]) ^ (a[2] & b[0]);
        return layer2 ? f : g;
    endfunction

    // Linear terms sit on the diagonal shares, the constant only on share (0,0).
    function automatic exp_t expand(input logic       layer2,
                                    input logic [3:0] s0,
                                    input logic [3:0] s1,
                                    input logic [3:0] s2);
        exp_t e;
        e[0] = q_term(layer2, s0, s0, 1'b1, 1'b1);
        e[1] = q_term(layer2, s0, s1, 1'b0, 1'b0);
        e[2] = q_term(layer2, s0, s2, 1'b0, 1'b0);
        e[3] = q_term(layer2, s1, s0, 1'b0, 1'b0);
        e[4] = q_term(layer2, s1, s1, 1'b1, 1'b0);
        e[5] = q_term(layer2, s1, s2, 1'b0, 1'b0);
        e[6] = q_term(layer2, s2, s0, 1'b0, 1'b0);
        e[7] = q_term(layer2, s2, s1, 1'b0, 1'b0);
        e[8] = q_term(layer2, s2, s2, 1'b1, 1'b0);
        return e;
    endfunction

    // Returns {sh2, sh1, sh0}; the two mask nibbles cancel in the share XOR.
    function automatic logic [11:0] compress(input exp_t e, input logic [7:0] r);
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] c2;
        c0 = e[0] ^ e[1] ^ e[2] ^ r[3:0];
        c1 = e[3] ^ e[4] ^ e[5] ^ r[7:4];
        c2 = e[6] ^ e[7] ^ e[8] ^ r[3:0] ^ r[7:4];
        return {c2, c1, c0};
    endfunction

    logic                    adv;
    logic                    e1_valid_q, e2_valid_q, out_valid_q;
    exp_t [NUM_SBOX-1:0]     e1_q, e1_d;
    exp_t [NUM_SBOX-1:0]     e2_q, e2_d;
    logic [RND_W-1:0]        e1_rnd_q;
    logic [8*NUM_SBOX-1:0]   e2_rnd_q, e2_rnd_d;
    logic [W-1:0]            out_sh0_q, out_sh1_q, out_sh2_q;
    logic [W-1:0]            out_sh0_d, out_sh1_d, out_sh2_d;

    assign adv           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sh0   = out_sh0_q;
    assign bus.out_sh1   = out_sh1_q;
    assign bus.out_sh2   = out_sh2_q;

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
        logic [11:0] c1;
        logic [11:0] c2;

        assign e1_d[k] = expand(1'b0, bus.in_sh0[4*k +: 4], bus.in_sh1[4*k +: 4],
                                bus.in_sh2[4*k +: 4]);
        assign c1      = compress(e1_q[k], e1_rnd_q[16*k +: 8]);
        assign e2_d[k] = expand(1'b1, c1[3:0], c1[7:4], c1[11:8]);
        // Layer-2 masks ride along one stage so rnd is consumed only at acceptance.
        assign e2_rnd_d[8*k +: 8] = e1_rnd_q[16*k+8 +: 8];
        assign c2      = compress(e2_q[k], e2_rnd_q[8*k +: 8]);
        assign out_sh0_d[4*k +: 4] = c2[3:0];
        assign out_sh1_d[4*k +: 4] = c2[7:4];
        assign out_sh2_d[4*k +: 4] = c2[11:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid_q  <= 1'b0;
            e2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            e1_q        <= '0;
            e1_rnd_q    <= '0;
            e2_q        <= '0;
            e2_rnd_q    <= '0;
            out_sh0_q   <= '0;
            out_sh1_q   <= '0;
            out_sh2_q   <= '0;
        end else if (adv) begin
            e1_valid_q  <= bus.in_valid;
            e2_valid_q  <= e1_valid_q;
            out_valid_q <= e2_valid_q;

            if (bus.in_valid) begin
                e1_q     <= e1_d;
                e1_rnd_q <= bus.rnd;
            end else if (ZERO_ON_IDLE) begin
                e1_q     <= '0;
                e1_rnd_q <= '0;
            end

            if (e1_valid_q) begin
                e2_q     <= e2_d;
                e2_rnd_q <= e2_rnd_d;
            end else if (ZERO_ON_IDLE) begin
                e2_q     <= '0;
                e2_rnd_q <= '0;
            end

            if (e2_valid_q) begin
                out_sh0_q <= out_sh0_d;
                out_sh1_q <= out_sh1_d;
                out_sh2_q <= out_sh2_d;
            end else if (ZERO_ON_IDLE) begin
                out_sh0_q <= '0;
                out_sh1_q <= '0;
                out_sh2_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ti3_present_sbox_pipe.sv
// Directed bench for the masked PRESENT S-box pipeline: table-driven stream plus
// hand-written stall, idle-zeroing and asynchronous-reset sequences.
module tb_ti3_present_sbox_pipe;
    localparam int unsigned NUM_SBOX = 16;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    vec_t       vecs[16];
    logic [63:0] snap0, snap1, snap2, first0, first1, first2;
    logic        var0, var1, var2;

    ti3_present_sbox_pipe_if #(.NUM_SBOX(NUM_SBOX)) bus_if ();

    ti3_present_sbox_pipe #(
        .NUM_SBOX    (NUM_SBOX),
        .ZERO_ON_IDLE(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] x);
        logic [63:0] s0;
        logic [63:0] s1;
        s0 = {$urandom(), $urandom()};
        s1 = {$urandom(), $urandom()};
        bus_if.in_valid = 1'b1;
        bus_if.in_sh0   = s0;
        bus_if.in_sh1   = s1;
        bus_if.in_sh2   = x ^ s0 ^ s1;
        for (int w = 0; w < 8; w++) bus_if.rnd[32*w +: 32] = $urandom();
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rep(input logic [3:0] n);
        return {16{n}};
    endfunction

    function automatic logic [63:0] unmasked();
        return bus_if.out_sh0 ^ bus_if.out_sh1 ^ bus_if.out_sh2;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        vecs[0]  = '{4'h0, 4'hC};  vecs[1]  = '{4'h1, 4'h5};
        vecs[2]  = '{4'h2, 4'h6};  vecs[3]  = '{4'h3, 4'hB};
        vecs[4]  = '{4'h4, 4'h9};  vecs[5]  = '{4'h5, 4'h0};
        vecs[6]  = '{4'h6, 4'hA};  vecs[7]  = '{4'h7, 4'hD};
        vecs[8]  = '{4'h8, 4'h3};  vecs[9]  = '{4'h9, 4'hE};
        vecs[10] = '{4'hA, 4'hF};  vecs[11] = '{4'hB, 4'h8};
        vecs[12] = '{4'hC, 4'h4};  vecs[13] = '{4'hD, 4'h7};
        vecs[14] = '{4'hE, 4'h1};  vecs[15] = '{4'hF, 4'h2};

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_sh0    = '0;
        bus_if.in_sh1    = '0;
        bus_if.in_sh2    = '0;
        bus_if.rnd       = '0;
        bus_if.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        check("rst_out_sh0", bus_if.out_sh0, 64'd0);
        check("rst_out_sh1", bus_if.out_sh1, 64'd0);
        check("rst_out_sh2", bus_if.out_sh2, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

        // Single transaction, exact 3-cycle latency, one-cycle valid
        drive(rep(4'h0));
        tick();
        idle();
        check("lat_c1_valid", {63'd0, bus_if.out_valid}, 64'd0);
        tick();
        check("lat_c2_valid", {63'd0, bus_if.out_valid}, 64'd0);
        tick();
        check("lat_c3_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("lat_c3_data", unmasked(), rep(4'hC));
        tick();
        check("lat_c4_valid", {63'd0, bus_if.out_valid}, 64'd0);
        tick();

        // Back-to-back stream through the full S-box table
        for (int t = 0; t < 18; t++) begin
            if (t < 16) drive(rep(vecs[t].x));
            else idle();
            tick();
            if (t < 2) begin
                check("stream_fill_valid", {63'd0, bus_if.out_valid}, 64'd0);
            end else begin
                check("stream_valid", {63'd0, bus_if.out_valid}, 64'd1);
                check("stream_data", unmasked(), rep(vecs[t-2].y));
            end
        end
        tick();
        check("stream_drained", {63'd0, bus_if.out_valid}, 64'd0);

        // Mask independence: x = 5 with fresh shares and randomness each time
        var0 = 1'b0;
        var1 = 1'b0;
        var2 = 1'b0;
        first0 = '0;
        first1 = '0;
        first2 = '0;
        for (int t = 0; t < 102; t++) begin
            if (t < 100) drive(rep(4'h5));
            else idle();
            tick();
            if (t >= 2) begin
                check("mask_data", unmasked(), 64'd0);
                if (t == 2) begin
                    first0 = bus_if.out_sh0;
                    first1 = bus_if.out_sh1;
                    first2 = bus_if.out_sh2;
                end else begin
                    var0 |= (bus_if.out_sh0 != first0);
                    var1 |= (bus_if.out_sh1 != first1);
                    var2 |= (bus_if.out_sh2 != first2);
                end
            end
        end
        check("mask_sh0_varies", {63'd0, var0}, 64'd1);
        check("mask_sh1_varies", {63'd0, var1}, 64'd1);
        check("mask_sh2_varies", {63'd0, var2}, 64'd1);
        idle();
        tick();
        tick();

        // Backpressure with A, F, 1 in flight
        drive(rep(4'hA));
        tick();
        drive(rep(4'hF));
        tick();
        drive(rep(4'h1));
        tick();
        check("bp_first_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("bp_first_data", unmasked(), rep(4'hF));
        snap0 = bus_if.out_sh0;
        snap1 = bus_if.out_sh1;
        snap2 = bus_if.out_sh2;
        bus_if.out_ready = 1'b0;
        drive(rep(4'h7));
        #1;
        check("bp_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
        for (int t = 0; t < 5; t++) begin
            drive(rep(4'h7));
            tick();
            check("bp_hold_valid", {63'd0, bus_if.out_valid}, 64'd1);
            check("bp_hold_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
            check("bp_hold_sh0", bus_if.out_sh0, snap0);
            check("bp_hold_sh1", bus_if.out_sh1, snap1);
            check("bp_hold_sh2", bus_if.out_sh2, snap2);
        end
        bus_if.out_ready = 1'b1;
        idle();
        tick();
        check("bp_rel1_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("bp_rel1_data", unmasked(), rep(4'h2));
        tick();
        check("bp_rel2_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("bp_rel2_data", unmasked(), rep(4'h5));
        tick();
        check("bp_rel3_valid", {63'd0, bus_if.out_valid}, 64'd0);
        tick();
        check("bp_rel4_valid", {63'd0, bus_if.out_valid}, 64'd0);

        // Idle zeroing after a single transaction drains
        drive(rep(4'h9));
        tick();
        idle();
        for (int t = 0; t < 4; t++) tick();
        tests++;
        if (dut.e1_q !== '0) begin
            fails++;
            $display("FAIL zero_e1: got nonzero E1 shares, expected all zero");
        end
        tests++;
        if (dut.e2_q !== '0) begin
            fails++;
            $display("FAIL zero_e2: got nonzero E2 shares, expected all zero");
        end
        check("zero_out_sh0", bus_if.out_sh0, 64'd0);
        check("zero_out_sh1", bus_if.out_sh1, 64'd0);
        check("zero_out_sh2", bus_if.out_sh2, 64'd0);

        // Asynchronous reset with two transactions in flight
        drive(rep(4'h6));
        tick();
        drive(rep(4'h8));
        tick();
        idle();
        bus_if.out_ready = 1'b0;
        tick();
        check("ar_pre_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("ar_pre_data", unmasked(), rep(4'hA));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_drop", {63'd0, bus_if.out_valid}, 64'd0);
        check("ar_sh0_zero", bus_if.out_sh0, 64'd0);
        check("ar_sh1_zero", bus_if.out_sh1, 64'd0);
        check("ar_sh2_zero", bus_if.out_sh2, 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("ar_no_stale", {63'd0, bus_if.out_valid}, 64'd0);
        end
        drive(rep(4'h3));
        tick();
        idle();
        tick();
        tick();
        check("ar_next_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("ar_next_data", unmasked(), rep(4'hB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
